// File: rtl/fb_pattern_writer.sv
// rtl/fb_pattern_writer.sv - Wishbone classic write master filling a linear framebuffer with a test pattern
module fb_pattern_writer #(
   parameter int          HDISP = 800,
   parameter int          VDISP = 480,
   parameter logic [31:0] BASE  = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        continuous,
   input  logic [1:0]  mode,
   input  logic [23:0] color,
   output logic [31:0] adr,
   output logic [31:0] dat_ms,
   output logic        we,
   output logic [3:0]  sel,
   output logic [2:0]  cti,
   output logic [1:0]  bte,
   output logic        cyc,
   output logic        stb,
   input  logic        ack,
   input  logic        err,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic        err_flag
);

   localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t        r_state;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [1:0]    r_mode;
   logic [23:0]   r_color;
   logic          r_busy;
   logic          r_stop_pending;
   logic          r_frame_done;
   logic [15:0]   r_frame_cnt;
   logic          r_err_flag;

   logic [31:0]   w_x32;
   logic [31:0]   w_y32;
   logic [31:0]   w_lin;
   logic [2:0]    w_bar;
   logic [23:0]   w_rgb;
   logic          w_last_x;
   logic          w_last_pix;
   logic          w_stop;
   logic [XW-1:0] w_x_next;
   logic [YW-1:0] w_y_next;

   assign w_x32      = 32'(r_x);
   assign w_y32      = 32'(r_y);
   assign w_lin      = w_y32 * 32'(HDISP) + w_x32;
   assign w_last_x   = (r_x == X_LAST);
   assign w_last_pix = w_last_x && (r_y == Y_LAST);
   assign w_stop     = stop || r_stop_pending;
   assign w_x_next   = w_last_x ? '0 : r_x + XW'(1);
   assign w_y_next   = !w_last_x ? r_y : ((r_y == Y_LAST) ? '0 : r_y + YW'(1));

   // Bar index = number of bar edges at or left of x; edges use integer division.
   always_comb begin
      w_bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (w_x32 >= 32'((i * HDISP) / 8)) w_bar = 3'(i);
      end
   end

   always_comb begin
      w_rgb = r_color;
      case (r_mode)
         2'd0: w_rgb = r_color;
         2'd1: begin
            case (w_bar)
               3'd0:    w_rgb = 24'hFFFFFF;
               3'd1:    w_rgb = 24'hFFFF00;
               3'd2:    w_rgb = 24'h00FFFF;
               3'd3:    w_rgb = 24'h00FF00;
               3'd4:    w_rgb = 24'hFF00FF;
               3'd5:    w_rgb = 24'hFF0000;
               3'd6:    w_rgb = 24'h0000FF;
               default: w_rgb = 24'h000000;
            endcase
         end
         2'd2:    w_rgb = (w_x32[4] ^ w_y32[4]) ? 24'h000000 : 24'hFFFFFF;
         default: w_rgb = {w_x32[7:0], w_y32[7:0], r_frame_cnt[7:0]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_x            <= '0;
         r_y            <= '0;
         r_mode         <= 2'd0;
         r_color        <= 24'h0;
         r_busy         <= 1'b0;
         r_stop_pending <= 1'b0;
         r_frame_done   <= 1'b0;
         r_frame_cnt    <= 16'h0;
         r_err_flag     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode         <= mode;
                  r_color        <= color;
                  r_x            <= '0;
                  r_y            <= '0;
                  r_err_flag     <= 1'b0;
                  r_stop_pending <= 1'b0;
                  r_busy         <= 1'b1;
                  r_state        <= S_WRITE;
               end
            end
            default: begin
               if (stop) r_stop_pending <= 1'b1;
               // err wins over a simultaneous ack: the same pixel is retried.
               if (err) begin
                  r_err_flag <= 1'b1;
               end else if (ack) begin
                  r_x <= w_x_next;
                  r_y <= w_y_next;
                  if (w_last_pix) begin
                     r_frame_done <= 1'b1;
                     r_frame_cnt  <= r_frame_cnt + 16'd1;
                  end
                  if (w_last_pix && continuous && !w_stop) begin
                     r_mode  <= mode;
                     r_color <= color;
                  end else if (w_last_pix || w_stop) begin
                     r_busy         <= 1'b0;
                     r_stop_pending <= 1'b0;
                     r_state        <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign adr        = BASE + (w_lin << 2);
   assign dat_ms     = {8'h00, w_rgb};
   assign we         = 1'b1;
   assign sel        = 4'b1111;
   assign cti        = 3'b000;
   assign bte        = 2'b00;
   assign cyc        = r_busy;
   assign stb        = r_busy;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;
   assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb/tb_fb_pattern_writer.sv - directed bench for fb_pattern_writer
module tb_fb_pattern_writer;

   logic        clk, rst_n;
   logic        start, stop, continuous, ack, err;
   logic [1:0]  mode;
   logic [23:0] color;
   logic [31:0] adr, dat_ms;
   logic        we, cyc, stb, busy, frame_done, err_flag;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [15:0] frame_cnt;

   logic        start2, ack2;
   logic [31:0] adr2, dat2;
   logic        we2, cyc2, stb2, busy2, fd2, ef2;
   logic [3:0]  sel2;
   logic [2:0]  cti2;
   logic [1:0]  bte2;
   logic [15:0] fc2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] wr_adr[$];
   logic [31:0] wr_dat[$];
   logic [31:0] err_adr_q[$];
   int          fd_q[$];
   int          stable_bad;
   logic [23:0] pix2[2048];
   logic [23:0] bars[8];

   fb_pattern_writer #(.HDISP(16), .VDISP(4), .BASE(32'h0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .mode(mode), .color(color), .adr(adr), .dat_ms(dat_ms), .we(we), .sel(sel),
      .cti(cti), .bte(bte), .cyc(cyc), .stb(stb), .ack(ack), .err(err), .busy(busy),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .err_flag(err_flag)
   );

   fb_pattern_writer #(.HDISP(64), .VDISP(32), .BASE(32'h100)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .continuous(1'b0),
      .mode(2'd2), .color(24'h0), .adr(adr2), .dat_ms(dat2), .we(we2), .sel(sel2),
      .cti(cti2), .bte(bte2), .cyc(cyc2), .stb(stb2), .ack(ack2), .err(1'b0), .busy(busy2),
      .frame_done(fd2), .frame_cnt(fc2), .err_flag(ef2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Slave responder; called and returning on a falling edge.
   task automatic slave_run(input int waits, input int err_at, input int stop_at,
                            input int cont_last, input int max_acks);
      int wait_cnt;
      int err_left;
      int ncyc;
      bit seen;
      logic [31:0] h_adr, h_dat;
      wait_cnt = 0; err_left = 2; ncyc = 0; seen = 0; h_adr = '0; h_dat = '0;
      wr_adr.delete(); wr_dat.delete(); err_adr_q.delete(); fd_q.delete();
      stable_bad = 0;
      forever begin
         ack = 1'b0; err = 1'b0; stop = 1'b0;
         if (frame_done) fd_q.push_back(wr_adr.size());
         if (max_acks > 0 && wr_adr.size() >= max_acks) break;
         if (stb) begin
            seen = 1;
            if (wait_cnt > 0 && (adr !== h_adr || dat_ms !== h_dat)) stable_bad++;
            if (wait_cnt == 0) begin h_adr = adr; h_dat = dat_ms; end
            if (wait_cnt < waits) wait_cnt++;
            else begin
               wait_cnt = 0;
               if (wr_adr.size() == err_at && err_left > 0) begin
                  err = 1'b1;
                  ack = (err_left == 1);
                  err_left--;
                  err_adr_q.push_back(adr);
               end else begin
                  ack = 1'b1;
                  if (wr_adr.size() == stop_at) stop = 1'b1;
                  wr_adr.push_back(adr);
                  wr_dat.push_back(dat_ms);
               end
            end
         end else if (seen) break;
         if (cont_last > 0 && fd_q.size() >= cont_last - 1) continuous = 1'b0;
         ncyc++;
         if (ncyc > 2000) begin
            n_tests++; n_fail++;
            $error("FAIL slave_timeout: observed %0d writes, required bus idle", wr_adr.size());
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int bad;
      int cnt2;
      logic [31:0] first2, idx;
      logic [31:0] exp;
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      rst_n = 1'b0; start = 0; stop = 0; continuous = 0; ack = 0; err = 0;
      mode = 2'd0; color = 24'h0; start2 = 0; ack2 = 0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", cyc, 0);       chk("rst_stb", stb, 0);
      chk("rst_busy", busy, 0);     chk("rst_fd", frame_done, 0);
      chk("rst_fcnt", frame_cnt, 0); chk("rst_eflag", err_flag, 0);
      chk("rst_adr", adr, 32'h0);   chk("rst_dat", dat_ms, 32'h0);
      chk("const_bus", {we, sel, cti, bte}, {1'b1, 4'hF, 3'd0, 2'd0});
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_cyc", cyc, 0);

      // Solid colour, ack every cycle
      mode = 2'd0; color = 24'h123456;
      pulse_start();
      chk("t1_cyc_rise", cyc, 1); chk("t1_busy", busy, 1);
      slave_run(0, -1, -1, 0, 0);
      chk("t1_nwr", wr_adr.size(), 64);
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++)
         if (wr_adr[i] !== 32'(i * 4) || wr_dat[i] !== 32'h00123456) bad++;
      chk("t1_data", bad, 0);
      chk("t1_fd_count", fd_q.size(), 1);
      chk("t1_fd_at", (fd_q.size() > 0) ? fd_q[0] : -1, 64);
      chk("t1_fcnt", frame_cnt, 1);
      chk("t1_idle", {cyc, stb, busy}, 3'b000);

      // Colour bars with 3 wait states
      mode = 2'd1;
      pulse_start();
      slave_run(3, -1, -1, 0, 0);
      chk("t2_nwr", wr_adr.size(), 64);
      chk("t2_stable", stable_bad, 0);
      chk("t2_x0", wr_dat[0], 32'hFFFFFF);
      chk("t2_x1", wr_dat[1], 32'hFFFFFF);
      chk("t2_x2", wr_dat[2], 32'hFFFF00);
      chk("t2_x14", wr_dat[14], 32'h000000);
      chk("t2_x15", wr_dat[15], 32'h000000);
      bad = 0;
      for (int i = 0; i < wr_dat.size(); i++)
         if (wr_dat[i] !== {8'h00, bars[(i % 16) / 2]}) bad++;
      chk("t2_bars", bad, 0);
      chk("t2_fcnt", frame_cnt, 2);

      // Stop together with the ack of pixel 10
      mode = 2'd0; color = 24'hABCDEF;
      pulse_start();
      slave_run(0, -1, 10, 0, 0);
      chk("t3_nwr", wr_adr.size(), 11);
      chk("t3_last_adr", wr_adr[wr_adr.size() - 1], 32'h28);
      chk("t3_idle", {cyc, busy}, 2'b00);
      chk("t3_no_fd", fd_q.size(), 0);
      chk("t3_fcnt", frame_cnt, 2);

      // Restart after stop, err on pixel 5 (second retry has ack+err together)
      color = 24'h00FF00;
      pulse_start();
      chk("t4_restart_adr", adr, 32'h0);
      slave_run(0, 5, -1, 0, 0);
      chk("t4_nwr", wr_adr.size(), 64);
      chk("t4_nerr", err_adr_q.size(), 2);
      chk("t4_err_adr0", err_adr_q[0], 32'h14);
      chk("t4_err_adr1", err_adr_q[1], 32'h14);
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++) if (wr_adr[i] !== 32'(i * 4)) bad++;
      chk("t4_adr_seq", bad, 0);
      chk("t4_eflag", err_flag, 1);
      chk("t4_fcnt", frame_cnt, 3);

      // Start clears err_flag; start while busy ignored; async reset mid-frame
      mode = 2'd3;
      pulse_start();
      chk("t5_eflag_clr", err_flag, 0);
      slave_run(0, -1, -1, 0, 20);
      chk("t5_adr20", adr, 32'h50);
      pulse_start();
      chk("t5_start_busy", adr, 32'h50);
      chk("t5_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_bus", {cyc, stb, busy}, 3'b000);
      chk("t5_rst_fcnt", frame_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Continuous gradient for three frames
      mode = 2'd3; continuous = 1'b1;
      pulse_start();
      slave_run(0, -1, -1, 3, 0);
      chk("t6_nwr_nogap", wr_adr.size(), 192);
      chk("t6_nfd", fd_q.size(), 3);
      chk("t6_fd0", (fd_q.size() > 0) ? fd_q[0] : -1, 64);
      chk("t6_fd1", (fd_q.size() > 1) ? fd_q[1] : -1, 128);
      chk("t6_fd2", (fd_q.size() > 2) ? fd_q[2] : -1, 192);
      chk("t6_fcnt", frame_cnt, 3);
      chk("t6_blue0", wr_dat[0], 32'h00000000);
      chk("t6_blue1", wr_dat[64], 32'h00000001);
      chk("t6_blue2", wr_dat[128], 32'h00000002);
      bad = 0;
      for (int i = 0; i < wr_dat.size(); i++) begin
         exp = {8'h00, 8'(i % 16), 8'((i / 16) % 4), 8'(i / 64)};
         if (wr_dat[i] !== exp || wr_adr[i] !== 32'((i % 64) * 4)) bad++;
      end
      chk("t6_grad", bad, 0);
      chk("t6_idle", busy, 0);

      // Checkerboard on a 64x32 instance with a non-zero base
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cnt2 = 0; first2 = 32'hFFFFFFFF;
      for (int c = 0; c < 2300; c++) begin
         ack2 = stb2;
         if (stb2) begin
            if (cnt2 == 0) first2 = adr2;
            idx = (adr2 - 32'h100) >> 2;
            if (idx < 2048) pix2[idx] = dat2[23:0];
            cnt2++;
         end else if (cnt2 > 0) break;
         @(negedge clk);
      end
      ack2 = 1'b0;
      chk("t7_nwr", cnt2, 2048);
      chk("t7_first_adr", first2, 32'h100);
      chk("t7_p0_0", pix2[0], 24'hFFFFFF);
      chk("t7_p16_0", pix2[16], 24'h000000);
      chk("t7_p16_16", pix2[16 * 64 + 16], 24'hFFFFFF);
      chk("t7_p0_16", pix2[16 * 64], 24'h000000);
      chk("t7_plast", pix2[2047], 24'hFFFFFF);
      chk("t7_fcnt", fc2, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_pattern_writer.md
Name: fb_pattern_writer

Overview:
- Wishbone classic write master. Fills the SDRAM framebuffer with a test pattern.
- It is the producer side of the video path. It writes the same linear layout that the VGA controller reads: address = BASE + (x + y*HDISP)*4, one 32-bit word per pixel, format {8'h00,R,G,B}.
- Sits on the Wishbone clock domain, in front of the SDRAM controller.
- Runs single-shot or continuously. Can be stopped cleanly at a transaction boundary.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE, 32'h0, byte base address of the framebuffer (word aligned).

Ports:
- clk  in  1  Wishbone clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  in  1  request to halt after the current write is acked.
- continuous  in  1  1 = restart at pixel 0 after the last pixel.
- mode  in  2  pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
- color  in  24  RGB value used by mode 0.
- adr  out  32  Wishbone byte address.
- dat_ms  out  32  Wishbone write data.
- we  out  1  constant 1.
- sel  out  4  constant 4'b1111.
- cti  out  3  constant 0.
- bte  out  2  constant 0.
- cyc  out  1  bus cycle.
- stb  out  1  strobe.
- ack  in  1  slave acknowledge.
- err  in  1  slave error.
- busy  out  1  1 in WRITE.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is acked.
- frame_cnt  out  16  completed frames, wraps.
- err_flag  out  1  sticky; set on any err, cleared by start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; x=y=0; cyc=stb=busy=frame_done=err_flag=0; frame_cnt=0; latched mode=0; latched color=0.
- State IDLE:
  - cyc=stb=0.
  - start=1: latch mode and color; x=y=0; clear err_flag; go to WRITE. cyc/stb rise the cycle after start.
  - stop is ignored in IDLE.
- State WRITE:
  - cyc=stb=1. adr and dat_ms are held stable until ack or err.
  - adr and dat_ms are functions of registered state only (x, y, latched mode/color, frame_cnt). There is no combinational path from ack/err.
  - ack=1: advance the pixel. x+1; at x=HDISP-1, x=0 and y+1.
  - New adr/dat appear the cycle after ack. stb stays high, so back-to-back acks give 1 pixel per cycle.
  - err=1 (ack=0): set err_flag, keep the same x,y and retry. ack and err both high: treat as err.
- Last pixel acked (x=HDISP-1, y=VDISP-1):
  - Pulse frame_done for one cycle; frame_cnt+1 (mod 2^16).
  - If continuous=1 and no stop pending: x=y=0, re-latch mode and color, stay in WRITE.
  - Otherwise go to IDLE.
- Stop:
  - stop=1 in WRITE sets stop_pending.
  - At the next ack, the pixel advances and the FSM goes to IDLE. cyc/stb are 0 the following cycle.
  - stop_pending is cleared on entering IDLE.
  - stop and ack in the same cycle: that ack is the last one.
  - stb is never dropped while a transaction is un-acked.
- start while busy: ignored.
- Patterns:
  - Mode 0: latched color.
  - Mode 1: 8 equal vertical bars. Bar i covers x in [i*HDISP/8, (i+1)*HDISP/8), integer division. Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Mode 2: (x[4]^y[4]) ? 000000 : FFFFFF.
  - Mode 3: R=x[7:0], G=y[7:0], B=frame_cnt[7:0].
- Arithmetic:
  - x width = $clog2(HDISP); y width = $clog2(VDISP).
  - Address is computed at 32 bits with no truncation: BASE + ((y*HDISP + x) << 2).
- Reset asserted mid-transaction: outputs drop immediately (asynchronous). The slave must tolerate an abandoned cycle.

Test Plan:
- HDISP=16, VDISP=4, mode 0, color=123456, continuous=0, slave acks every cycle.
  - Expect 64 writes at adr 0x00..0xFC, all with dat 0x00123456.
  - frame_done pulses once; frame_cnt=1; then IDLE.
- Mode 1, HDISP=16, slave inserts 3 wait states per access.
  - Expect x=0,1 -> FFFFFF, x=2 -> FFFF00, x=14,15 -> 000000.
  - adr/dat stable during the waits.
- Mode 2, HDISP=64, VDISP=32.
  - Expect pixel (0,0) = FFFFFF, (16,0) = 000000, (16,16) = FFFFFF.
- Continuous=1, mode 3, 3 frames.
  - Expect frame_done pulses 64 acks apart; frame_cnt=3.
  - Blue byte = 0,1,2 across the frames; no stb gap at the frame wrap.
- Stop asserted at pixel 10 in the same cycle as its ack.
  - Expect exactly 11 writes, cyc=0 on the next cycle, busy=0.
  - A later start restarts at adr BASE.
- err on pixel 5.
  - Expect adr 0x14 repeated until ack, err_flag=1, and 64 total acked writes.
  - err_flag is cleared by the next start.
- rst_n pulled low mid-frame.
  - Expect cyc/stb/busy=0 immediately and frame_cnt=0.
